// File: rtl/riscy_pkg.sv
// Shared types and line levels for the processor IO-port serial transmitter.
package riscy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered FULL/EMPTY flags decoded from the next occupancy.
module sync_fifo #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr,
    input  logic [DATA_SIZE-1:0]          wr_data,
    input  logic                          rd,
    output logic [DATA_SIZE-1:0]          rd_data_c,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_d;
    logic                 wr_acc;
    logic                 rd_acc;

    // A write seen while full is dropped even if a pop frees a slot in the same cycle.
    assign wr_acc    = wr & ~full;
    assign rd_acc    = rd & ~empty;
    assign count_d   = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    assign rd_data_c = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(FIFO_DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/port_uart_tx.sv
// Captures IO-port writes into a FIFO and shifts them out as 8N1 serial frames, LSB first.
module port_uart_tx
    import riscy_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_SIZE-1:0] PORT_DATA,
    input  logic                 PORT_WR,
    input  logic                 CLR_OVF,
    output logic                 TX,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 BUSY,
    output logic                 OVF
);

    localparam int unsigned BAUD_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

    tx_state_t            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_SIZE-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q;
    logic                 ovf_q, ovf_d;
    logic                 pop_c;
    logic [DATA_SIZE-1:0] head_c;
    logic [CNT_W-1:0]     fifo_count;

    sync_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .wr        (PORT_WR),
        .wr_data   (PORT_DATA),
        .rd        (pop_c),
        .rd_data_c (head_c),
        .full      (FULL),
        .empty     (EMPTY),
        .count     (fifo_count)
    );

    // Next-state logic; TX is computed one cycle ahead so the line comes straight from a flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = TX_IDLE;
                if (!EMPTY) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    baud_d  = BAUD_LAST;
                    tx_d    = TX_START;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_LAST;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_LAST;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = TX_IDLE;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == '0) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (!EMPTY) begin
                        pop_c   = 1'b1;
                        shift_d = head_c;
                        baud_d  = BAUD_LAST;
                        tx_d    = TX_START;
                        state_d = START;
                    end else begin
                        tx_d    = TX_IDLE;
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = TX_IDLE;
                state_d = IDLE;
            end
        endcase
    end

    // Sticky overflow; a dropped write beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (PORT_WR && FULL) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= TX_IDLE;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != IDLE);
            ovf_q   <= ovf_d;
        end
    end

    assign TX   = tx_q;
    assign BUSY = busy_q;
    assign OVF  = ovf_q;

    // FIFO occupancy never exceeds its depth.
    a_count_bound: assert property (@(posedge CLK) disable iff (!RST)
        fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_port_uart_tx.sv
// Scoreboarded bench: stimulus queues expected bytes, a serial-line monitor decodes and compares frames.
module tb_port_uart_tx;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DIV   = 4;
    localparam int unsigned FLEN  = (DW + 2) * DIV;
    localparam int          LIMIT = 2000;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] PORT_DATA;
    logic          PORT_WR;
    logic          CLR_OVF;
    logic          TX;
    logic          FULL;
    logic          EMPTY;
    logic          BUSY;
    logic          OVF;

    int            pass_cnt;
    int            total_cnt;
    logic [DW-1:0] sb[$];

    port_uart_tx #(
        .DATA_SIZE  (DW),
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (DIV)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .PORT_DATA (PORT_DATA),
        .PORT_WR   (PORT_WR),
        .CLR_OVF   (CLR_OVF),
        .TX        (TX),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .BUSY      (BUSY),
        .OVF       (OVF)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic wr_byte(input logic [DW-1:0] b, input bit accept);
        @(negedge CLK);
        PORT_DATA = b;
        PORT_WR   = 1'b1;
        if (accept) sb.push_back(b);
    endtask

    task automatic wr_end();
        @(negedge CLK);
        PORT_WR = 1'b0;
    endtask

    task automatic wr_when_ready(input logic [DW-1:0] b);
        int n;
        n = 0;
        @(negedge CLK);
        while (FULL && n < LIMIT) begin
            PORT_WR = 1'b0;
            @(negedge CLK);
            n++;
        end
        check("ready_timeout", 32'(n < LIMIT), 32'd1);
        PORT_DATA = b;
        PORT_WR   = 1'b1;
        sb.push_back(b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge CLK);
        while (!(BUSY == 1'b0 && EMPTY == 1'b1 && TX == 1'b1) && n < LIMIT) begin
            @(negedge CLK);
            n++;
        end
        check({name, "_idle"}, 32'(n < LIMIT), 32'd1);
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic clear_ovf();
        @(negedge CLK);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        check("ovf_cleared", 32'(OVF), 32'd0);
    endtask

    // Serial receiver: samples every cycle of a frame, checks bit-cell shape, then scores the byte.
    initial begin : monitor
        logic [FLEN-1:0] smp;
        logic [DW-1:0]   got;
        logic            shape_ok;
        logic            aborted;
        forever begin
            @(negedge CLK);
            if (RST === 1'b1 && TX === 1'b0) begin
                aborted = 1'b0;
                smp     = '0;
                for (int c = 0; c < int'(FLEN); c++) begin
                    if (c > 0) @(negedge CLK);
                    if (RST !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    smp[c] = TX;
                end
                if (!aborted) begin
                    shape_ok = 1'b1;
                    for (int c = 0; c < int'(FLEN); c++) begin
                        if (smp[c] !== smp[(c / DIV) * DIV]) shape_ok = 1'b0;
                    end
                    if (smp[0] !== 1'b0 || smp[(DW + 1) * DIV] !== 1'b1) shape_ok = 1'b0;
                    for (int i = 0; i < int'(DW); i++) got[i] = smp[(i + 1) * DIV];
                    check("frame_shape", 32'(shape_ok), 32'd1);
                    check("frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        check("frame_data", 32'(got), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        pass_cnt  = 0;
        total_cnt = 0;
        PORT_DATA = '0;
        PORT_WR   = 1'b0;
        CLR_OVF   = 1'b0;
        RST       = 1'b1;
        #1 RST = 1'b0;
        #1;
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_ovf", 32'(OVF), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Single byte: latency and exact frame length.
        wr_byte(8'hA5, 1'b1);
        wr_end();
        check("single_empty_after_write", 32'(EMPTY), 32'd0);
        check("single_tx_still_idle", 32'(TX), 32'd1);
        check("single_busy_not_yet", 32'(BUSY), 32'd0);
        @(negedge CLK);
        check("single_start_tx", 32'(TX), 32'd0);
        check("single_start_busy", 32'(BUSY), 32'd1);
        check("single_empty_after_pop", 32'(EMPTY), 32'd1);
        repeat (FLEN - 1) @(negedge CLK);
        check("single_last_stop_busy", 32'(BUSY), 32'd1);
        check("single_last_stop_tx", 32'(TX), 32'd1);
        @(negedge CLK);
        check("single_done_busy", 32'(BUSY), 32'd0);
        wait_idle("single");

        // Back-to-back: second frame starts right after the first stop bit.
        wr_byte(8'h01, 1'b1);
        wr_byte(8'h80, 1'b1);
        wr_end();
        check("b2b_first_start", 32'(TX), 32'd0);
        check("b2b_not_empty", 32'(EMPTY), 32'd0);
        repeat (FLEN - 1) @(negedge CLK);
        check("b2b_stop1", 32'(TX), 32'd1);
        @(negedge CLK);
        check("b2b_no_gap_tx", 32'(TX), 32'd0);
        check("b2b_no_gap_busy", 32'(BUSY), 32'd1);
        check("b2b_empty_after_pop2", 32'(EMPTY), 32'd1);
        wait_idle("b2b");

        // Overflow: 0x10 goes to the shifter, 0x11..0x14 fill the FIFO, 0x15 is dropped.
        for (int i = 0; i < 6; i++) begin
            wr_byte(8'h10 + 8'(i), i < 5);
        end
        wr_end();
        check("ovf_full", 32'(FULL), 32'd1);
        check("ovf_set", 32'(OVF), 32'd1);
        clear_ovf();
        wait_idle("ovf");

        // Full FIFO at the STOP->START pop with a concurrent write and clear: write dropped, set wins.
        wr_byte(8'h30, 1'b1);
        for (int i = 1; i < 5; i++) begin
            wr_byte(8'h30 + 8'(i), 1'b1);
        end
        wr_end();
        check("popw_full", 32'(FULL), 32'd1);
        check("popw_ovf_pre", 32'(OVF), 32'd0);
        repeat (FLEN - 5) @(negedge CLK);
        wr_byte(8'h35, 1'b0);
        CLR_OVF = 1'b1;
        check("popw_still_stop", 32'(TX), 32'd1);
        wr_end();
        CLR_OVF = 1'b0;
        check("popw_ovf_set", 32'(OVF), 32'd1);
        check("popw_full_after_pop", 32'(FULL), 32'd0);
        check("popw_not_empty", 32'(EMPTY), 32'd0);
        check("popw_next_start", 32'(TX), 32'd0);
        clear_ovf();
        wait_idle("popw");

        // Pointer wrap: 12 bytes, each written only while FULL is low.
        for (int i = 0; i < 12; i++) begin
            wr_when_ready(8'h20 + 8'(i));
        end
        wr_end();
        wait_idle("wrap");
        check("wrap_ovf", 32'(OVF), 32'd0);

        // Reset mid-frame with buffered data and OVF set: everything clears asynchronously.
        for (int i = 0; i < 6; i++) begin
            wr_byte(8'h40 + 8'(i), 1'b0);
        end
        wr_end();
        repeat (10) @(negedge CLK);
        check("mid_pre_busy", 32'(BUSY), 32'd1);
        check("mid_pre_ovf", 32'(OVF), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_tx", 32'(TX), 32'd1);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_empty", 32'(EMPTY), 32'd1);
        check("mid_rst_full", 32'(FULL), 32'd0);
        check("mid_rst_ovf", 32'(OVF), 32'd0);
        sb.delete();
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_tx", 32'(TX), 32'd1);
        check("post_rst_empty", 32'(EMPTY), 32'd1);
        wr_byte(8'h5A, 1'b1);
        wr_end();
        wait_idle("post_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
